// File: rtl/mem_arb_if.sv
// Bus bundle for the memory arbiter: instruction-fetch port, data port,
// unified single-port memory port and status.
// The slave modport is the arbiter's view; master is the client/memory side.
interface mem_arb_if;
   logic        hlt;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_rdy;
   logic [15:0] if_data;
   logic        dm_re;
   logic        dm_we;
   logic [15:0] dm_addr;
   logic [15:0] dm_wdata;
   logic        dm_rdy;
   logic [15:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        stall;
   logic        err;

   modport slave (
      input  hlt, if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdy, if_data, dm_rdy, dm_rdata, mem_en, mem_we, mem_addr,
             mem_wdata, stall, err
   );

   modport master (
      output hlt, if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdy, if_data, dm_rdy, dm_rdata, mem_en, mem_we, mem_addr,
             mem_wdata, stall, err
   );
endinterface

// File: rtl/mem_arb.sv
// Arbiter sharing one single-port memory between instruction fetch and data
// accesses. Data requests win, except that after two back-to-back data grants
// with a fetch waiting, the fetch is served next. Every access holds the
// memory for MEM_LAT cycles, then spends one response cycle pulsing rdy.
module mem_arb #(
   parameter int MEM_LAT = 2            // memory latency in cycles, 1..7
) (
   input logic      clk,
   input logic      rst_n,
   mem_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

   state_t     state;
   logic [2:0] cnt;        // access cycles remaining after the current one
   logic [1:0] fair_cnt;   // data grants in a row while a fetch was waiting

   logic dm_req;
   logic if_pend;
   logic dm_first;

   // Grant decision terms; only acted upon while the FSM is in IDLE.
   always_comb begin
      dm_req   = bus.dm_re | bus.dm_we;
      if_pend  = bus.if_req & ~bus.hlt;
      dm_first = dm_req & ~(if_pend & (fair_cnt == 2'd2));
   end

   // Pipeline stall: a requester is waiting and is not being answered now.
   assign bus.stall = (bus.if_req & ~bus.hlt & ~bus.if_rdy) |
                      ((bus.dm_re | bus.dm_we) & ~bus.dm_rdy);

   // Arbitration FSM with registered memory-side and response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         fair_cnt      <= '0;
         bus.if_rdy    <= 1'b0;
         bus.dm_rdy    <= 1'b0;
         bus.if_data   <= '0;
         bus.dm_rdata  <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so the later case arms
         // can override these one-cycle pulse defaults without ordering races.
         bus.if_rdy <= 1'b0;
         bus.dm_rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.dm_re && bus.dm_we) bus.err <= 1'b1;
               if (dm_first) begin
                  state         <= DM_ACC;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= bus.dm_we;
                  bus.mem_addr  <= bus.dm_addr;
                  bus.mem_wdata <= bus.dm_wdata;
                  cnt           <= CNT_LOAD;
                  fair_cnt      <= if_pend ? fair_cnt + 2'd1 : 2'd0;
               end else if (if_pend) begin
                  state         <= IF_ACC;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= bus.if_addr;
                  bus.mem_wdata <= '0;
                  cnt           <= CNT_LOAD;
                  fair_cnt      <= 2'd0;
               end else begin
                  fair_cnt <= 2'd0;
               end
            end
            IF_ACC, DM_ACC: begin
               if (cnt == 3'd0) begin
                  if (state == IF_ACC) begin
                     bus.if_data <= bus.mem_rdata;
                     bus.if_rdy  <= 1'b1;
                  end else begin
                     // A write leaves the previous read data in place.
                     if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
                     bus.dm_rdy <= 1'b1;
                  end
                  bus.mem_en    <= 1'b0;
                  bus.mem_we    <= 1'b0;
                  bus.mem_addr  <= '0;
                  bus.mem_wdata <= '0;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles; legal range 1..7.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 hlt  input  1  processor halted; blocks new instruction grants.
REQ-005 if_req  input  1  instruction fetch request; level, held until if_rdy.
REQ-006 if_addr  input  16  fetch word address.
REQ-007 if_rdy  output  1  one-cycle pulse; if_data is valid.
REQ-008 if_data  output  16  fetched instruction, registered.
REQ-009 dm_re  input  1  data read request; level, held until dm_rdy.
REQ-010 dm_we  input  1  data write request; level, held until dm_rdy.
REQ-011 dm_addr  input  16  data word address.
REQ-012 dm_wdata  input  16  write data.
REQ-013 dm_rdy  output  1  one-cycle pulse; access complete, and dm_rdata is valid for a read.
REQ-014 dm_rdata  output  16  read data, registered.
REQ-015 mem_en  output  1  unified single-port memory enable.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  16  memory address.
REQ-018 mem_wdata  output  16  memory write data.
REQ-019 mem_rdata  input  16  memory read data; valid in the last access cycle.
REQ-020 stall  output  1  combinational pipeline stall.
REQ-021 err  output  1  sticky protocol error flag.

Function
REQ-022 The FSM SHALL have states IDLE, IF_ACC, DM_ACC and RESP.
REQ-023 Requests SHALL be sampled only in IDLE; a request arriving at edge T moves the FSM to the access state at T+1.
REQ-024 On grant, the block SHALL latch addr, wdata and we, and load the latency counter with MEM_LAT-1.
REQ-025 In IF_ACC and DM_ACC, mem_en SHALL be 1 and mem_addr/mem_wdata SHALL drive the latched values, stable for MEM_LAT cycles.
REQ-026 mem_we SHALL be 1 only in DM_ACC of a write access; otherwise mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-027 The counter SHALL decrement each access cycle.
REQ-028 At counter==0, mem_rdata SHALL be captured into if_data (IF_ACC) or dm_rdata (DM read) and the FSM SHALL enter RESP.
REQ-029 In RESP, exactly one of if_rdy/dm_rdy SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; total latency from request to rdy is MEM_LAT+1 cycles.
REQ-030 A data write SHALL leave dm_rdata unchanged.
REQ-031 Priority: a data request SHALL win over if_req, except when two consecutive DM grants occurred while if_req was pending; then IF SHALL be granted next.
REQ-032 The fairness count SHALL clear on any IF grant and on any IDLE cycle without a data request.
REQ-033 if_req SHALL be ignored while hlt=1; data requests SHALL still be served under hlt.
REQ-034 An access in progress when hlt rises SHALL complete normally.
REQ-035 A request withdrawn mid-access SHALL NOT abort the access; rdy SHALL still pulse.
REQ-036 dm_re and dm_we asserted together in IDLE SHALL be treated as a write and SHALL set err.
REQ-037 err SHALL be cleared only by reset.
REQ-038 stall SHALL equal (if_req & ~hlt & ~if_rdy) | ((dm_re|dm_we) & ~dm_rdy).
REQ-039 MEM_LAT=1 SHALL give exactly one access cycle.
REQ-040 if_rdy and dm_rdy SHALL never be 1 in the same cycle.

Reset
REQ-041 With rst_n=0 at an edge, state SHALL become IDLE and the counter and fairness count SHALL become 0.
REQ-042 With rst_n=0 at an edge, if_rdy, dm_rdy, if_data, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata and err SHALL become 0.
REQ-043 Reset asserted mid-access SHALL abandon the access with no rdy pulse.
REQ-044 The first grant after reset SHALL be sampled in the cycle after rst_n returns to 1.

Verification (MEM_LAT=2)
REQ-045 IF read:
- Stimulus: if_req=1, if_addr=0x0010, mem_rdata=0xB123.
- Response: mem_en=1 for 2 cycles with addr 0x0010; if_rdy pulses at request+3 with if_data=0xB123.
REQ-046 Simultaneous requests:
- Stimulus: if_req and dm_re (addr 0x0040) both asserted in IDLE.
- Response: DM is served first, dm_rdy at +3; the IF grant follows and if_rdy arrives at +7.
REQ-047 Fairness:
- Stimulus: if_req held while dm_re is re-asserted continuously.
- Response: the third grant goes to IF.
REQ-048 Write:
- Stimulus: dm_we=1, addr 0x0100, wdata 0x5A5A.
- Response: mem_we=1 for 2 cycles with 0x5A5A; dm_rdata unchanged; dm_rdy pulses.
REQ-049 Reset mid-access:
- Stimulus: rst_n=0 in the second IF_ACC cycle.
- Response: all outputs 0 next cycle; no if_rdy pulse.
REQ-050 Error and halt:
- Stimulus: dm_re=dm_we=1, then hlt=1 with if_req=1.
- Response: a write is performed and err=1 stays set; no IF grant occurs while hlt=1.
